vram_arbiter: RTL and testbench

- Arbitrates one single-port synchronous video RAM (SB_RAM-style, 1-cycle read latency) between three requesters:
  - the pixel/character fetch engine feeding the pixel generator, which has absolute priority;
  - host command writes from the command processor, via a write queue;
  - host command readback.
- Display fetches are never stalled; host traffic uses the cycles the display leaves idle.

---
 rtl/vram_arbiter.sv | 169 ++++++++++++++++
 tb/tb_vram_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: display fetch has absolute priority, host
// writes drain from a small FIFO, host readback runs only once the FIFO is empty.
module vram_arbiter #(
  parameter int ADDR_W   = 13,
  parameter int DATA_W   = 8,
  parameter int WQ_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        fetch_req,
  input  logic [ADDR_W-1:0]           fetch_addr,
  output logic                        fetch_valid,
  output logic [DATA_W-1:0]           fetch_data,
  input  logic                        wr_req,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [DATA_W-1:0]           wr_data,
  output logic                        wr_ready,
  output logic [$clog2(WQ_DEPTH):0]   wq_count,
  input  logic                        hrd_req,
  input  logic [ADDR_W-1:0]           hrd_addr,
  output logic                        hrd_busy,
  output logic                        hrd_valid,
  output logic [DATA_W-1:0]           hrd_data,
  output logic [ADDR_W-1:0]           ram_addr,
  output logic                        ram_we,
  output logic [DATA_W-1:0]           ram_wdata,
  input  logic [DATA_W-1:0]           ram_rdata
);

  // state    | meaning
  // RB_IDLE  | no readback outstanding
  // RB_WAIT  | address latched, waiting for a free slot with an empty queue
  // RB_DONE  | read issued last cycle, hrd_valid pulse with ram_rdata

  localparam int PTR_W = $clog2(WQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_FETCH,
    SLOT_WRITE,
    SLOT_READ
  } slot_t;

  typedef enum logic [1:0] {
    RB_IDLE,
    RB_WAIT,
    RB_DONE
  } rb_state_t;

  logic [ADDR_W-1:0] wq_addr [WQ_DEPTH];
  logic [DATA_W-1:0] wq_data [WQ_DEPTH];
  logic [PTR_W-1:0]  wq_wptr;
  logic [PTR_W-1:0]  wq_rptr;
  logic [CNT_W-1:0]  wq_cnt_q;
  logic              wq_full;
  logic              wq_empty;
  logic              push;
  logic              pop;

  rb_state_t         rb_state;
  rb_state_t         rb_next;
  logic [ADDR_W-1:0] rb_addr;
  logic [DATA_W-1:0] hrd_data_q;
  logic              rb_waiting;

  logic              fetch_pend;
  logic [ADDR_W-1:0] last_addr;
  slot_t             slot;

  assign wq_full    = (wq_cnt_q == CNT_W'(WQ_DEPTH));
  assign wq_empty   = (wq_cnt_q == '0);
  assign rb_waiting = (rb_state == RB_WAIT);

  // Readiness uses only registered state, so a full queue never accepts in a pop cycle.
  assign wr_ready = !rst && !wq_full && !rb_waiting;
  assign push     = wr_req && wr_ready;
  assign pop      = (slot == SLOT_WRITE);

  always_comb begin
    slot = SLOT_IDLE;
    if (rst)
      slot = SLOT_IDLE;
    else if (fetch_req)
      slot = SLOT_FETCH;
    else if (!wq_empty)
      slot = SLOT_WRITE;
    else if (rb_waiting)
      slot = SLOT_READ;
  end

  always_comb begin
    ram_addr  = last_addr;
    ram_we    = 1'b0;
    ram_wdata = wq_data[wq_rptr];
    case (slot)
      SLOT_FETCH: ram_addr = fetch_addr;
      SLOT_WRITE: begin
        ram_addr = wq_addr[wq_rptr];
        ram_we   = 1'b1;
      end
      SLOT_READ:  ram_addr = rb_addr;
      default:    ram_addr = last_addr;
    endcase
  end

  // Queue storage needs no reset; the pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      wq_addr[wq_wptr] <= wr_addr;
      wq_data[wq_wptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wq_wptr    <= '0;
      wq_rptr    <= '0;
      wq_cnt_q   <= '0;
      fetch_pend <= 1'b0;
      last_addr  <= '0;
      hrd_data_q <= '0;
      rb_addr    <= '0;
    end else begin
      if (push)
        wq_wptr <= wq_wptr + 1'b1;
      if (pop)
        wq_rptr <= wq_rptr + 1'b1;
      case ({push, pop})
        2'b10:   wq_cnt_q <= wq_cnt_q + 1'b1;
        2'b01:   wq_cnt_q <= wq_cnt_q - 1'b1;
        default: wq_cnt_q <= wq_cnt_q;
      endcase
      fetch_pend <= fetch_req;
      if (slot != SLOT_IDLE)
        last_addr <= ram_addr;
      if (rb_state == RB_DONE)
        hrd_data_q <= ram_rdata;
      if ((rb_state != RB_WAIT) && hrd_req)
        rb_addr <= hrd_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      rb_state <= RB_IDLE;
    else
      rb_state <= rb_next;
  end

  always_comb begin
    rb_next = rb_state;
    case (rb_state)
      RB_IDLE: if (hrd_req) rb_next = RB_WAIT;
      RB_WAIT: if (slot == SLOT_READ) rb_next = RB_DONE;
      RB_DONE: rb_next = hrd_req ? RB_WAIT : RB_IDLE;
      default: rb_next = RB_IDLE;
    endcase
  end

  // Registered flags are masked during reset so in-flight results never escape.
  assign fetch_valid = fetch_pend && !rst;
  assign fetch_data  = ram_rdata;
  assign hrd_busy    = rb_waiting && !rst;
  assign hrd_valid   = (rb_state == RB_DONE) && !rst;
  assign hrd_data    = rst ? '0 : (hrd_valid ? ram_rdata : hrd_data_q);
  assign wq_count    = rst ? '0 : wq_cnt_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed tables and sequences plus
// randomized traffic against a queue-based reference model and a behavioural RAM.
module tb_vram_arbiter;
  localparam int AW = 13;
  localparam int DW = 8;
  localparam int D  = 4;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_valid;
  logic [DW-1:0] fetch_data;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic [CW-1:0] wq_count;
  logic          hrd_req;
  logic [AW-1:0] hrd_addr;
  logic          hrd_busy;
  logic          hrd_valid;
  logic [DW-1:0] hrd_data;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  always #5 clk = ~clk;

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WQ_DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .wq_count(wq_count),
    .hrd_req(hrd_req), .hrd_addr(hrd_addr), .hrd_busy(hrd_busy),
    .hrd_valid(hrd_valid), .hrd_data(hrd_data),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // Behavioural single-port RAM, read-first, one cycle read latency.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          mem_clr;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  // Reference model state
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;
  wr_t           q[$];
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  bit            m_busy, m_fv, m_hv, m_last_ok;
  logic [AW-1:0] m_raddr, m_last;
  logic [DW-1:0] m_fd, m_hd;

  logic          o_fv, o_hv, o_busy, o_rdy, o_we;
  logic [DW-1:0] o_fd, o_hd;
  logic [CW-1:0] o_cnt;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Check the current cycle against the model, then advance both by one clock.
  task automatic step();
    int            owner;
    logic [AW-1:0] ea;
    logic [DW-1:0] ewd;
    bit            erdy, old_busy;
    owner = 0; ea = '0; ewd = '0; erdy = 1'b0;
    #1;
    o_fv = fetch_valid; o_fd = fetch_data; o_hv = hrd_valid; o_hd = hrd_data;
    o_busy = hrd_busy; o_rdy = wr_ready; o_we = ram_we; o_cnt = wq_count;
    if (rst) begin
      chk("rst_fetch_valid", fetch_valid, 0);
      chk("rst_hrd_valid", hrd_valid, 0);
      chk("rst_hrd_busy", hrd_busy, 0);
      chk("rst_hrd_data", hrd_data, 0);
      chk("rst_wq_count", wq_count, 0);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_wr_ready", wr_ready, 0);
      q.delete();
      m_busy = 0; m_fv = 0; m_hv = 0; m_hd = '0; m_last_ok = 0;
    end else begin
      erdy = (q.size() < D) && !m_busy;
      if (fetch_req) begin
        owner = 1; ea = fetch_addr;
      end else if (q.size() > 0) begin
        owner = 2; ea = q[0].a; ewd = q[0].d;
      end else if (m_busy) begin
        owner = 3; ea = m_raddr;
      end else begin
        owner = 0; ea = m_last;
      end
      chk("fetch_valid", fetch_valid, m_fv);
      if (m_fv) chk("fetch_data", fetch_data, m_fd);
      chk("hrd_valid", hrd_valid, m_hv);
      chk("hrd_data", hrd_data, m_hd);
      chk("hrd_busy", hrd_busy, m_busy);
      chk("wq_count", wq_count, q.size());
      chk("wr_ready", wr_ready, erdy);
      chk("ram_we", ram_we, owner == 2);
      if (owner != 0 || m_last_ok) chk("ram_addr", ram_addr, ea);
      if (owner == 2) chk("ram_wdata", ram_wdata, ewd);

      old_busy = m_busy;
      m_fv = fetch_req;
      if (fetch_req) m_fd = shadow[fetch_addr];
      m_hv = (owner == 3);
      if (owner == 3) begin
        m_hd = shadow[m_raddr];
        m_busy = 0;
      end
      if (owner == 2) begin
        shadow[q[0].a] = q[0].d;
        void'(q.pop_front());
      end
      if (owner != 0) begin
        m_last = ea;
        m_last_ok = 1;
      end
      if (wr_req && erdy) q.push_back('{a: wr_addr, d: wr_data});
      if (hrd_req && !old_busy) begin
        m_busy = 1;
        m_raddr = hrd_addr;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input bit fr, input logic [AW-1:0] fa, input bit wr,
                       input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input bit hr, input logic [AW-1:0] ha);
    fetch_req = fr; fetch_addr = fa;
    wr_req = wr; wr_addr = wa; wr_data = wd;
    hrd_req = hr; hrd_addr = ha;
    step();
  endtask

  typedef struct {
    bit            fr;
    bit            wr;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    int            cnt;
    bit            rdy;
    bit            we;
  } vec_t;
  vec_t tbl [11];

  initial begin
    // Write-priority vectors: fetch holds the port while the queue fills, then it drains.
    tbl[0]  = '{1, 1, 13'h100, 8'h11, 0, 1, 0};
    tbl[1]  = '{1, 1, 13'h101, 8'h12, 1, 1, 0};
    tbl[2]  = '{1, 1, 13'h102, 8'h13, 2, 1, 0};
    tbl[3]  = '{1, 1, 13'h103, 8'h14, 3, 1, 0};
    tbl[4]  = '{1, 1, 13'h104, 8'h99, 4, 0, 0};
    tbl[5]  = '{1, 0, 13'h000, 8'h00, 4, 0, 0};
    tbl[6]  = '{0, 0, 13'h000, 8'h00, 4, 0, 1};
    tbl[7]  = '{0, 0, 13'h000, 8'h00, 3, 1, 1};
    tbl[8]  = '{0, 0, 13'h000, 8'h00, 2, 1, 1};
    tbl[9]  = '{0, 0, 13'h000, 8'h00, 1, 1, 1};
    tbl[10] = '{0, 0, 13'h000, 8'h00, 0, 1, 0};

    for (int i = 0; i < (1 << AW); i++) shadow[i] = '0;
    m_raddr = '0; m_last = '0; m_fd = '0;
    rst = 1'b1; mem_clr = 1'b1;
    fetch_req = 0; fetch_addr = '0; wr_req = 0; wr_addr = '0; wr_data = '0;
    hrd_req = 0; hrd_addr = '0;
    step();
    mem_clr = 1'b0;
    step();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("post_rst_fetch_valid", o_fv, 0);
    chk("post_rst_wq_count", o_cnt, 0);

    // Fetch only, after preloading three bytes through the write queue
    drive(0, 0, 1, 13'h010, 8'hA5, 0, 0);
    drive(0, 0, 1, 13'h011, 8'h5A, 0, 0);
    drive(0, 0, 1, 13'h012, 8'hFF, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 13'h010, 0, 0, 0, 0, 0);
    drive(1, 13'h011, 0, 0, 0, 0, 0);
    chk("fetch0_valid", o_fv, 1); chk("fetch0_data", o_fd, 8'hA5); chk("fetch0_we", o_we, 0);
    drive(1, 13'h012, 0, 0, 0, 0, 0);
    chk("fetch1_valid", o_fv, 1); chk("fetch1_data", o_fd, 8'h5A); chk("fetch1_we", o_we, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("fetch2_valid", o_fv, 1); chk("fetch2_data", o_fd, 8'hFF); chk("fetch2_we", o_we, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("fetch3_valid", o_fv, 0);

    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].fr, 13'h020, tbl[i].wr, tbl[i].wa, tbl[i].wd, 0, 0);
      chk($sformatf("tbl%0d_cnt", i), o_cnt, tbl[i].cnt);
      chk($sformatf("tbl%0d_rdy", i), o_rdy, tbl[i].rdy);
      chk($sformatf("tbl%0d_we", i), o_we, tbl[i].we);
    end

    // Interleave: writes only in fetch-free cycles, fetch latency unchanged
    drive(1, 13'h100, 1, 13'h500, 8'h61, 0, 0);
    drive(1, 13'h101, 1, 13'h501, 8'h62, 0, 0);
    drive(1, 13'h102, 1, 13'h502, 8'h63, 0, 0);
    for (int i = 0; i < 6; i++) begin
      drive(i % 2 == 0, 13'h103, 0, 0, 0, 0, 0);
      chk($sformatf("ilv%0d_we", i), o_we, i % 2 == 1);
      chk($sformatf("ilv%0d_fv", i), o_fv, (i == 0) || (i % 2 == 1));
    end

    // Full queue: no enqueue in the pop cycle, enqueue on the next one
    drive(1, 13'h020, 1, 13'h600, 8'h41, 0, 0);
    drive(1, 13'h020, 1, 13'h600, 8'h42, 0, 0);
    drive(1, 13'h020, 1, 13'h600, 8'h43, 0, 0);
    drive(1, 13'h020, 1, 13'h600, 8'h44, 0, 0);
    drive(0, 13'h020, 1, 13'h601, 8'h55, 0, 0);
    chk("full_cnt", o_cnt, 4); chk("full_rdy", o_rdy, 0); chk("full_we", o_we, 1);
    drive(1, 13'h020, 1, 13'h601, 8'h55, 0, 0);
    chk("refill_cnt", o_cnt, 3); chk("refill_rdy", o_rdy, 1);
    drive(1, 13'h020, 0, 0, 0, 0, 0);
    chk("refilled_cnt", o_cnt, 4);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0, 0, 0);
    chk("drained_cnt", o_cnt, 0);

    // Readback ordering: the read must see a write accepted just before it
    drive(1, 13'h020, 1, 13'h200, 8'h3C, 0, 0);
    drive(1, 13'h020, 0, 0, 0, 1, 13'h200);
    chk("rb_acc_cnt", o_cnt, 1); chk("rb_acc_busy", o_busy, 0);
    drive(1, 13'h020, 0, 0, 0, 0, 0);
    chk("rb_wait_busy", o_busy, 1); chk("rb_wait_rdy", o_rdy, 0); chk("rb_wait_hv", o_hv, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("rb_commit_we", o_we, 1); chk("rb_commit_rdy", o_rdy, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("rb_issue_hv", o_hv, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("rb_done_hv", o_hv, 1); chk("rb_done_hd", o_hd, 8'h3C); chk("rb_done_busy", o_busy, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("rb_hold_hv", o_hv, 0); chk("rb_hold_hd", o_hd, 8'h3C);

    // Reset mid-operation
    drive(1, 13'h020, 1, 13'h300, 8'h71, 0, 0);
    drive(1, 13'h020, 1, 13'h301, 8'h72, 0, 0);
    drive(1, 13'h020, 1, 13'h302, 8'h73, 0, 0);
    drive(1, 13'h020, 0, 0, 0, 1, 13'h300);
    drive(1, 13'h020, 0, 0, 0, 0, 0);
    chk("pre_rst_cnt", o_cnt, 3); chk("pre_rst_busy", o_busy, 1);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("mid_rst_cnt", o_cnt, 0); chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_hv", o_hv, 0); chk("mid_rst_we", o_we, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("mid_rst_hv2", o_hv, 0); chk("mid_rst_we2", o_we, 0);
    drive(1, 13'h300, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("mid_rst_discard_fv", o_fv, 1); chk("mid_rst_discard_fd", o_fd, 8'h00);

    // Randomized traffic over a small address window so reads hit recent writes
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 399) == 0);
      drive($urandom_range(0, 99) < 55, 13'h400 + 13'($urandom_range(0, 15)),
            $urandom_range(0, 1) == 1, 13'h400 + 13'($urandom_range(0, 15)),
            8'($urandom_range(0, 255)),
            $urandom_range(0, 3) == 0, 13'h400 + 13'($urandom_range(0, 15)));
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
